// File: rtl/vector_lane_alu_pkg.sv
// vector_lane_alu_pkg: shared types, sizes and per-opcode timing for the vector lanes
package vector_lane_alu_pkg;
  localparam int VECTOR_REG_WIDTH  = 64;
  localparam int NUM_OF_VECTOR_REG = 8;
  localparam int NUM_OF_LANES      = 4;
  typedef enum logic [2:0] {
    SADD = 3'd0,
    SSUB = 3'd1,
    SMUL = 3'd2,
    SDIV = 3'd3
  } function_opcode_t;
  typedef enum logic [1:0] {IDLE, EXEC, WB} lane_state_t;
  function automatic int exec_cycles(function_opcode_t op, int mul_latency, int width);
    return op == SMUL ? mul_latency : op == SDIV ? width : 1;
  endfunction
endpackage

// File: rtl/vector_lane_alu_lane_divider.sv
// vector_lane_alu_lane_divider: iterative restoring signed divider, one quotient bit per cycle
module vector_lane_alu_lane_divider #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient
);
  localparam int CW = $clog2(W);
  logic          run_q, run_d, neg_q, neg_d, zero_q, zero_d, fit;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, rem_n, quo_n;
  logic [W:0]    sh;
  assign sh    = {rem_q, quo_q[W-1]};
  assign fit   = sh >= {1'b0, dvs_q};
  assign rem_n = fit ? W'(sh - {1'b0, dvs_q}) : sh[W-1:0];
  assign quo_n = {quo_q[W-2:0], fit};
  // The final bit is resolved combinationally so the quotient is ready after W-1 stored steps
  assign done     = run_q && cnt_q == CW'(W - 1);
  assign quotient = zero_q ? '1 : neg_q ? -quo_n : quo_n;
  always_comb begin
    run_d  = run_q;
    neg_d  = neg_q;
    zero_d = zero_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    if (start) begin
      run_d  = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = dividend[W-1] ? -dividend : dividend;
      dvs_d  = divisor[W-1] ? -divisor : divisor;
      neg_d  = dividend[W-1] ^ divisor[W-1];
      zero_d = divisor == '0;
    end else if (run_q && !done) begin
      rem_d = rem_n;
      quo_d = quo_n;
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q  <= 1'b0;
      neg_q  <= 1'b0;
      zero_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      run_q  <= run_d;
      neg_q  <= neg_d;
      zero_q <= zero_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end
endmodule

// File: rtl/vector_lane_alu.sv
// vector_lane_alu: one vector execution lane computing an element op and writing it back
module vector_lane_alu #(
  parameter int   VECTOR_REG_WIDTH  = vector_lane_alu_pkg::VECTOR_REG_WIDTH,
  parameter int   NUM_OF_VECTOR_REG = vector_lane_alu_pkg::NUM_OF_VECTOR_REG,
  parameter int   ELEM_IDX_WIDTH    = 32,
  parameter int   MUL_LATENCY       = 3,
  localparam int  PW                = $clog2(NUM_OF_VECTOR_REG)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  vld,
  input  logic [VECTOR_REG_WIDTH-1:0]           data0,
  input  logic [VECTOR_REG_WIDTH-1:0]           data1,
  input  logic [PW-1:0]                         vec_reg_in,
  input  logic [ELEM_IDX_WIDTH-1:0]             elem_idx,
  input  vector_lane_alu_pkg::function_opcode_t functional_opcode,
  output logic                                  busy,
  output logic                                  wb_vld,
  output logic [PW-1:0]                         wb_vec_reg_ptr,
  output logic [ELEM_IDX_WIDTH-1:0]             wb_addr,
  output logic [VECTOR_REG_WIDTH-1:0]           wb_data,
  input  logic                                  wb_grant,
  output logic [1:0]                            err_status
);
  import vector_lane_alu_pkg::*;
  localparam int CW = $clog2(VECTOR_REG_WIDTH > MUL_LATENCY ? VECTOR_REG_WIDTH : MUL_LATENCY) + 1;
  lane_state_t                 state_q, state_d;
  function_opcode_t            op_q, op_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [VECTOR_REG_WIDTH-1:0] a_q, a_d, b_q, b_d, mul_q, mul_d, wb_data_q, wb_data_d, div_q, result;
  logic [PW-1:0]               ptr_q, ptr_d;
  logic [ELEM_IDX_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]                  err_q, err_d;
  logic                        busy_q, busy_d, wb_vld_q, wb_vld_d, legal, accept, div_done, last;
  assign legal  = functional_opcode inside {SADD, SSUB, SMUL, SDIV};
  assign accept = state_q == IDLE && vld && legal;
  assign last   = cnt_q == '0 && (op_q != SDIV || div_done);
  assign result = op_q == SADD ? a_q + b_q : op_q == SSUB ? a_q - b_q : op_q == SMUL ? mul_q : div_q;
  vector_lane_alu_lane_divider #(.W(VECTOR_REG_WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (accept && functional_opcode == SDIV),
    .dividend (data0),
    .divisor  (data1),
    .done     (div_done),
    .quotient (div_q)
  );
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    mul_d     = mul_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    wb_vld_d  = wb_vld_q;
    wb_data_d = wb_data_q;
    err_d     = err_q | {state_q == IDLE && vld && !legal, vld && busy_q};
    // The product is formed once at accept and simply held while the counter runs out
    if (accept) begin
      state_d = EXEC;
      busy_d  = 1'b1;
      op_d    = functional_opcode;
      a_d     = data0;
      b_d     = data1;
      mul_d   = data0 * data1;
      ptr_d   = vec_reg_in;
      addr_d  = elem_idx;
      cnt_d   = CW'(exec_cycles(functional_opcode, MUL_LATENCY, VECTOR_REG_WIDTH) - 1);
    end
    if (state_q == EXEC) begin
      cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      if (last) begin
        state_d   = WB;
        wb_vld_d  = 1'b1;
        wb_data_d = result;
      end
    end
    if (state_q == WB && wb_grant) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      wb_vld_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= SADD;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mul_q     <= '0;
      ptr_q     <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      wb_vld_q  <= 1'b0;
      wb_data_q <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mul_q     <= mul_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      wb_vld_q  <= wb_vld_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end
  assign busy           = busy_q;
  assign wb_vld         = wb_vld_q;
  assign wb_vec_reg_ptr = ptr_q;
  assign wb_addr        = addr_q;
  assign wb_data        = wb_data_q;
  assign err_status     = err_q;
endmodule

// File: tb/tb_vector_lane_alu.sv
// tb_vector_lane_alu: directed and randomized ops checked against a plain arithmetic model
module tb_vector_lane_alu;
  import vector_lane_alu_pkg::*;
  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAX_POS = 64'h7FFF_FFFF_FFFF_FFFF;
  logic             clk = 1'b0, reset = 1'b0, vld = 1'b0, wb_grant = 1'b0;
  logic [63:0]      data0 = '0, data1 = '0;
  logic [2:0]       vec_reg_in = '0;
  logic [31:0]      elem_idx = '0;
  function_opcode_t functional_opcode = SADD;
  logic             busy, wb_vld;
  logic [2:0]       wb_vec_reg_ptr;
  logic [31:0]      wb_addr;
  logic [63:0]      wb_data;
  logic [1:0]       err_status;
  int               total = 0, bad = 0;
  always #5 clk = ~clk;
  vector_lane_alu dut (
    .clk               (clk),
    .reset             (reset),
    .vld               (vld),
    .data0             (data0),
    .data1             (data1),
    .vec_reg_in        (vec_reg_in),
    .elem_idx          (elem_idx),
    .functional_opcode (functional_opcode),
    .busy              (busy),
    .wb_vld            (wb_vld),
    .wb_vec_reg_ptr    (wb_vec_reg_ptr),
    .wb_addr           (wb_addr),
    .wb_data           (wb_data),
    .wb_grant          (wb_grant),
    .err_status        (err_status)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] model(function_opcode_t op, logic [63:0] a, logic [63:0] b);
    longint sa, sb;
    sa = signed'(a);
    sb = signed'(b);
    case (op)
      SADD:    return a + b;
      SSUB:    return a - b;
      SMUL:    return a * b;
      default: return sb == 0 ? '1 : (a == MIN_NEG && sb == -1) ? MIN_NEG : 64'(sa / sb);
    endcase
  endfunction
  function automatic int lat_of(function_opcode_t op);
    return op == SMUL ? 3 : op == SDIV ? 64 : 1;
  endfunction
  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 64'd1;
      2:       return '1;
      3:       return MIN_NEG;
      4:       return MAX_POS;
      default: return {$urandom, $urandom} >> $urandom_range(0, 63);
    endcase
  endfunction
  task automatic do_op(input function_opcode_t op, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] ptr, input logic [31:0] idx, input int hold, input bit poke);
    logic [63:0] exp;
    int lat;
    exp = model(op, a, b);
    functional_opcode = op;
    data0 = a;
    data1 = b;
    vec_reg_in = ptr;
    elem_idx = idx;
    vld = 1'b1;
    tick();
    vld = poke;
    check("busy_accept", busy, 1);
    lat = 0;
    do begin
      data0 = {$urandom, $urandom};
      data1 = {$urandom, $urandom};
      vec_reg_in = 3'($urandom);
      elem_idx = $urandom;
      wb_grant = 1'($urandom);
      tick();
      vld = 1'b0;
      lat++;
    end while (!wb_vld && lat < 200);
    wb_grant = 1'b0;
    check("latency", 64'(lat), 64'(lat_of(op)));
    check("wb_data", wb_data, exp);
    check("wb_ptr", wb_vec_reg_ptr, ptr);
    check("wb_addr", wb_addr, idx);
    check("busy_wb", busy, 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_vld", wb_vld, 1);
      check("hold_data", wb_data, exp);
      check("hold_ptr", wb_vec_reg_ptr, ptr);
      check("hold_addr", wb_addr, idx);
    end
    wb_grant = 1'b1;
    tick();
    wb_grant = 1'b0;
    check("grant_vld", wb_vld, 0);
    check("grant_busy", busy, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_busy", busy, 0);
    check("rst_wb_vld", wb_vld, 0);
    check("rst_err", err_status, 0);
    check("rst_data", wb_data, 0);
    check("rst_ptr", wb_vec_reg_ptr, 0);
    check("rst_addr", wb_addr, 0);
    do_op(SADD, 64'd5, -64'sd7, 3'd2, 32'd9, 0, 1'b0);
    do_op(SADD, MAX_POS, 64'd1, 3'd1, 32'd3, 0, 1'b0);
    do_op(SSUB, 64'd0, 64'd1, 3'd7, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(SMUL, 64'h1_0000_0000, 64'h1_0000_0001, 3'd4, 32'd17, 0, 1'b0);
    do_op(SDIV, -64'sd7, 64'd2, 3'd5, 32'd1, 0, 1'b0);
    do_op(SDIV, 64'd10, 64'd0, 3'd6, 32'd2, 0, 1'b0);
    do_op(SDIV, MIN_NEG, '1, 3'd3, 32'd4, 0, 1'b0);
    do_op(SSUB, 64'd100, 64'd42, 3'd2, 32'd77, 10, 1'b0);
    for (int n = 0; n < 30; n++)
      do_op(function_opcode_t'(3'($urandom_range(0, 3))), pick(), pick(), 3'($urandom),
            $urandom, $urandom_range(0, 3), 1'b0);
    check("err_clean", err_status, 2'b00);
    do_op(SMUL, -64'sd3, 64'd11, 3'd1, 32'd8, 0, 1'b1);
    check("err_drop", err_status, 2'b01);
    functional_opcode = function_opcode_t'(3'd5);
    vld = 1'b1;
    tick();
    vld = 1'b0;
    check("err_illegal", err_status, 2'b11);
    check("illegal_busy", busy, 0);
    check("illegal_wb", wb_vld, 0);
    tick();
    check("illegal_wb2", wb_vld, 0);
    check("illegal_busy2", busy, 0);
    functional_opcode = SDIV;
    data0 = 64'd1000;
    data1 = 64'd7;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    repeat (20) tick();
    reset = 1'b0;
    #1;
    check("middiv_busy", busy, 0);
    check("middiv_wb", wb_vld, 0);
    check("middiv_err", err_status, 0);
    tick();
    reset = 1'b1;
    tick();
    do_op(SDIV, 64'd1000, 64'd7, 3'd0, 32'd5, 1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vector_lane_alu.md
Name: vector_lane_alu

Overview:
- One functional lane downstream of the execution unit; one instance per lane, NUM_OF_LANES instances in total.
- Accepts one element operation (two operands, destination vector register, element index, function opcode) and computes it over one or more cycles.
- Writes the result back to the vector register file through a valid/grant handshake.
- Reports busy so the execution unit's next-free-lane search skips it.

Parameters:
VECTOR_REG_WIDTH, 64, operand/result width in bits
NUM_OF_VECTOR_REG, 8, number of vector registers (sets destination pointer width)
ELEM_IDX_WIDTH, 32, element index width (matches the vector length register)
MUL_LATENCY, 3, cycles spent in EXEC for SMUL (minimum 1)

Ports:
clk  input  1  sole clock; one clock domain
reset  input  1  asynchronous, active-low reset
vld  input  1  op request from the execution unit; sampled only when busy=0
data0  input  VECTOR_REG_WIDTH  operand A
data1  input  VECTOR_REG_WIDTH  operand B
vec_reg_in  input  clog2(NUM_OF_VECTOR_REG)  destination vector register
elem_idx  input  ELEM_IDX_WIDTH  destination element index
functional_opcode  input  function_opcode_t  SADD/SSUB/SMUL/SDIV
busy  output  1  lane occupied (registered)
wb_vld  output  1  writeback request
wb_vec_reg_ptr  output  clog2(NUM_OF_VECTOR_REG)  writeback register
wb_addr  output  ELEM_IDX_WIDTH  writeback element index
wb_data  output  VECTOR_REG_WIDTH  result
wb_grant  input  1  register file accepts the writeback this cycle
err_status  output  2  sticky flags: [0] vld dropped while busy, [1] illegal opcode

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low. Reset asserted at any time, including mid-divide or while wb_vld is high, immediately forces state IDLE.
- Reset values: busy=0, wb_vld=0, wb_vec_reg_ptr=0, wb_addr=0, wb_data=0, err_status=0, cycle counter=0.
- FSM states: IDLE, EXEC, WB.
- IDLE: if vld=1, latch operands, pointer, index and opcode; go to EXEC; busy=1 from the next cycle.
- IDLE, illegal opcode: if vld=1 with an opcode not in {SADD, SSUB, SMUL, SDIV}, set err_status[1], stay IDLE, no writeback, busy stays 0.
- EXEC cycle counts N: SADD and SSUB N=1; SMUL N=MUL_LATENCY; SDIV N=VECTOR_REG_WIDTH (one quotient bit per cycle).
- EXEC counter: loaded with N-1 on accept, decrements each cycle. At 0: register the result into wb_data, set wb_vld=1, go to WB.
- Latency: with the accept edge as edge 0, wb_vld is first high after edge N.
- WB: wb_vld, wb_vec_reg_ptr, wb_addr and wb_data are held stable until a cycle with wb_vld=1 and wb_grant=1.
- On that grant edge: wb_vld=0, busy=0, go to IDLE. A new vld is accepted no earlier than the following edge; there is no same-cycle reuse. wb_grant while wb_vld=0 is ignored.
- vld=1 while busy=1: request dropped, err_status[0] set. Sticky; cleared only by reset.
- Arithmetic is two's complement on VECTOR_REG_WIDTH bits:
  - SADD/SSUB: wrap modulo 2^W; no overflow flag.
  - SMUL: low W bits of the signed full product.
  - SDIV: signed quotient truncated toward zero.
  - SDIV by zero: quotient all-ones.
  - SDIV of most-negative by -1: most-negative.
- Operands, pointer and index are captured at accept. Input changes during EXEC/WB have no effect.

Decomposition:
- Shared package:
  - function_opcode_t: extend with SSUB, SMUL, SDIV alongside SADD.
  - lane_state_t: IDLE, EXEC, WB.
  - VECTOR_REG_WIDTH, NUM_OF_VECTOR_REG, NUM_OF_LANES.
- Sub-module lane_divider: iterative restoring signed divider.
  - start/done handshake; W cycles; sign fix-up and both divide corner cases inside.
  - Instantiated once per lane.
- Add and multiply stay inline. The multiply result is registered and held for MUL_LATENCY cycles by the EXEC counter.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> busy=0, wb_vld=0, err_status=0. SADD data0=5, data1=-7, vec_reg_in=2, elem_idx=9 -> wb_vld high after edge 1, wb_data=-2, ptr=2, addr=9, busy=1 until the grant edge.
- Wrap: SADD 0x7FFF_FFFF_FFFF_FFFF + 1 -> wb_data=0x8000_0000_0000_0000. SSUB 0 - 1 -> all-ones.
- SMUL 0x1_0000_0000 * 0x1_0000_0001 with MUL_LATENCY=3 -> wb_vld first high after edge 3; wb_data=0x1_0000_0000 (low 64 bits).
- SDIV:
  - -7/2 -> -3 after edge 64.
  - 10/0 -> all-ones.
  - 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
  - Reset pulsed mid-divide -> immediate IDLE, busy=0, wb_vld=0.
- Back-pressure: hold wb_grant=0 for 10 cycles after wb_vld rises -> all wb_* stable. Grant for one cycle -> wb_vld=0 and busy=0 on that edge; the next vld is accepted one edge later.
- Errors: vld pulsed during EXEC -> err_status=2'b01, the in-flight result is unchanged. Undefined opcode from IDLE -> err_status[1]=1, no wb_vld, busy stays 0.
